// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/LSU memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Watchdog counter width: enough to hold TIMEOUT_CYC, never less than one bit.
    function automatic int unsigned wd_width(input int unsigned timeout_cyc);
        int unsigned w;
        w = $clog2(timeout_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped as one bus.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    // Instruction fetch requester
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_err;

    // Load/store requester
    logic                  ls_req;
    logic                  ls_we;
    logic [DATA_W/8-1:0]   ls_be;
    logic [ADDR_W-1:0]     ls_addr;
    logic [DATA_W-1:0]     ls_wdata;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_W-1:0]     ls_rdata;
    logic                  ls_err;

    // Shared memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Requesters plus memory view
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time gets it.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,        // [0] = fetch, [1] = LSU
    input  owner_e     last_owner,
    output logic [1:0] grant,      // one-hot, zero when nobody requests
    output owner_e     owner
);

    // Pick a winner from the current requests and the previous owner.
    always_comb begin
        grant = '0;
        owner = OWN_IF;
        unique case (req)
            2'b01: begin
                grant = 2'b01;
                owner = OWN_IF;
            end
            2'b10: begin
                grant = 2'b10;
                owner = OWN_LS;
            end
            2'b11: begin
                if (last_owner == OWN_LS) begin
                    grant = 2'b01;
                    owner = OWN_IF;
                end else begin
                    grant = 2'b10;
                    owner = OWN_LS;
                end
            end
            default: begin
                grant = '0;
                owner = OWN_IF;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the LSU.
// Round-robin grant in IDLE, one memory access in ACCESS, one response pulse in RESP.
// A watchdog aborts accesses that sit in ACCESS for TIMEOUT_CYC cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned WD_W = wd_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);

    arb_state_e          state;
    owner_e              last_owner;
    owner_e              owner_q;
    owner_e              pick_owner;
    logic [1:0]          pick_grant;
    logic                any_gnt;

    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                mem_req_q;

    logic                if_rvalid_q;
    logic                if_err_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                ls_rvalid_q;
    logic                ls_err_q;
    logic [DATA_W-1:0]   ls_rdata_q;

    logic [WD_W-1:0]     wd_cnt;
    logic                wd_expired;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.ls_req, bus.if_req}),
        .last_owner (last_owner),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    // Grants are only offered while idle; the picker guarantees one-hot.
    assign any_gnt    = (state == IDLE) && (pick_grant != 2'b00);
    assign bus.if_gnt = (state == IDLE) && pick_grant[0];
    assign bus.ls_gnt = (state == IDLE) && pick_grant[1];

    assign wd_expired = (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_err    = if_err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ls_rdata  = ls_rdata_q;

    // Access sequencer: latches the winner's payload, runs the memory access and watchdog, returns the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_owner  <= OWN_LS;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
            wd_cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_gnt) begin
                        owner_q    <= pick_owner;
                        last_owner <= pick_owner;
                        mem_req_q  <= 1'b1;
                        wd_cnt     <= '0;
                        state      <= ACCESS;
                        if (pick_owner == OWN_LS) begin
                            addr_q  <= bus.ls_addr;
                            we_q    <= bus.ls_we;
                            be_q    <= bus.ls_be;
                            wdata_q <= bus.ls_wdata;
                        end else begin
                            // Fetch is a full-word read; write data is left as it was.
                            addr_q  <= bus.if_addr;
                            we_q    <= 1'b0;
                            be_q    <= '1;
                        end
                    end
                end
                ACCESS: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    // An ack in the watchdog's last cycle still completes normally.
                    if (bus.mem_ack || wd_expired) begin
                        mem_req_q <= 1'b0;
                        state     <= RESP;
                        if (owner_q == OWN_IF) begin
                            if_rvalid_q <= 1'b1;
                            if_err_q    <= !bus.mem_ack;
                            if_rdata_q  <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            ls_rvalid_q <= 1'b1;
                            ls_err_q    <= !bus.mem_ack;
                            ls_rdata_q  <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    if_rvalid_q <= 1'b0;
                    if_err_q    <= 1'b0;
                    ls_rvalid_q <= 1'b0;
                    ls_err_q    <= 1'b0;
                    wd_cnt      <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued at grant and
// checked when the matching rvalid pulse appears.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned TO = 4;

    typedef struct packed {
        owner_e      owner;
        logic [31:0] data;
        logic        err;
        logic [15:0] len;
        logic [31:0] gcyc;
    } exp_t;

    logic clk;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    exp_t        sb[$];
    owner_e      gl_owner[$];
    int unsigned gl_cyc[$];

    int unsigned cyc     = 0;
    int unsigned ack_lat = 1;       // mem_req cycles up to and including ack; 0 = never ack
    logic [31:0] ack_data = '0;
    int unsigned mcnt    = 0;

    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_chk_wdata;
    int unsigned exp_len;
    int unsigned run_len = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after ack_lat cycles of mem_req
    always @(negedge clk) begin
        if (bus.mem_req) begin
            mcnt++;
            bus.mem_ack   = (ack_lat != 0) && (mcnt == ack_lat);
            bus.mem_rdata = bus.mem_ack ? ack_data : 32'h0BAD_0BAD;
        end else begin
            mcnt        = 0;
            bus.mem_ack = 1'b0;
        end
    end

    // Monitor: grant log, scoreboard push/pop, payload stability, mem_req length
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (bus.if_gnt && bus.ls_gnt) chk("both_gnt", 1, 0);
            if (bus.if_gnt || bus.ls_gnt) begin
                e.owner = bus.ls_gnt ? OWN_LS : OWN_IF;
                e.gcyc  = cyc;
                if (ack_lat == 0 || ack_lat > TO) begin
                    e.len  = 16'(TO);
                    e.data = '0;
                    e.err  = 1'b1;
                end else begin
                    e.len  = 16'(ack_lat);
                    e.data = ack_data;
                    e.err  = 1'b0;
                end
                sb.push_back(e);
                gl_owner.push_back(e.owner);
                gl_cyc.push_back(cyc);
                exp_len = e.len;
                if (bus.ls_gnt) begin
                    exp_addr      = bus.ls_addr;
                    exp_we        = bus.ls_we;
                    exp_be        = bus.ls_be;
                    exp_wdata     = bus.ls_wdata;
                    exp_chk_wdata = 1'b1;
                end else begin
                    exp_addr      = bus.if_addr;
                    exp_we        = 1'b0;
                    exp_be        = 4'hF;
                    exp_chk_wdata = 1'b0;
                end
            end
            if (bus.mem_req) begin
                run_len++;
                chk("mem_addr", bus.mem_addr, exp_addr);
                chk("mem_we", bus.mem_we, exp_we);
                chk("mem_be", bus.mem_be, exp_be);
                if (exp_chk_wdata) chk("mem_wdata", bus.mem_wdata, exp_wdata);
            end else if (run_len != 0) begin
                chk("mem_req_len", run_len, exp_len);
                run_len = 0;
            end
            if (bus.if_rvalid || bus.ls_rvalid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rvalid", {bus.ls_rvalid, bus.if_rvalid}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_latency", cyc - e.gcyc, e.len + 1);
                    if (e.owner == OWN_IF) begin
                        chk("if_rvalid_only", {bus.ls_rvalid, bus.if_rvalid}, 2'b01);
                        chk("if_rdata", bus.if_rdata, e.data);
                        chk("if_err", bus.if_err, e.err);
                        chk("ls_err_idle", bus.ls_err, 0);
                    end else begin
                        chk("ls_rvalid_only", {bus.ls_rvalid, bus.if_rvalid}, 2'b10);
                        chk("ls_rdata", bus.ls_rdata, e.data);
                        chk("ls_err", bus.ls_err, e.err);
                        chk("if_err_idle", bus.if_err, 0);
                    end
                end
            end
        end
    end

    task automatic do_req(input bit ls, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit got;
        if (ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = we;
            bus.ls_be    = be;
            bus.ls_addr  = addr;
            bus.ls_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ls ? bus.ls_gnt : bus.if_gnt;
        end
        if (!got) chk(ls ? "ls_gnt_wait" : "if_gnt_wait", 0, 1);
        @(posedge clk);
        #1;
        // Requester moves on; the arbiter must keep its latched copy.
        bus.if_req   = 1'b0;
        bus.ls_req   = 1'b0;
        bus.ls_addr  = 32'hDEAD_BEEF;
        bus.ls_wdata = ~wdata;
        bus.ls_be    = ~be;
        bus.ls_we    = ~we;
        bus.if_addr  = 32'hFEED_F00D;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) chk("resp_wait", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int unsigned n);
        for (int i = 0; i < 40 && gl_owner.size() < n; i++) @(negedge clk);
        if (gl_owner.size() < n) chk("grant_wait", gl_owner.size(), n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = '0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_ls_rvalid", bus.ls_rvalid, 0);
        chk("rst_if_err", bus.if_err, 0);
        chk("rst_ls_rdata", bus.ls_rdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_gnt", {bus.ls_gnt, bus.if_gnt}, 0);

        // Contention straight after reset: fetch first, then alternate, 3 cycles apart
        ack_lat      = 1;
        ack_data     = 32'h1111_2222;
        bus.if_addr  = 32'h0000_0080;
        bus.ls_addr  = 32'h0000_0040;
        bus.ls_we    = 1'b0;
        bus.ls_be    = 4'hF;
        bus.ls_wdata = 32'h0;
        bus.if_req   = 1'b1;
        bus.ls_req   = 1'b1;
        wait_grants(4);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        wait_idle();
        chk("cont_count", gl_owner.size(), 4);
        if (gl_owner.size() == 4) begin
            chk("cont_own0", gl_owner[0], OWN_IF);
            chk("cont_own1", gl_owner[1], OWN_LS);
            chk("cont_own2", gl_owner[2], OWN_IF);
            chk("cont_own3", gl_owner[3], OWN_LS);
            for (int i = 1; i < 4; i++) chk("cont_spacing", gl_cyc[i] - gl_cyc[i-1], 3);
        end
        gl_owner.delete();
        gl_cyc.delete();

        // Single fetch, ack on the third mem_req cycle
        ack_lat  = 3;
        ack_data = 32'h0051_3093;
        do_req(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
        wait_idle();

        // LSU byte write
        ack_lat  = 2;
        ack_data = 32'h0000_0077;
        do_req(1'b1, 1'b1, 4'b0100, 32'h0000_2002, 32'hAABB_CCDD);
        wait_idle();

        // Timeout with no ack, then a normal fetch
        ack_lat  = 0;
        ack_data = 32'h5555_5555;
        do_req(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
        wait_idle();
        ack_lat  = 2;
        ack_data = 32'h0000_CAFE;
        do_req(1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
        wait_idle();

        // Ack on the watchdog's last cycle wins
        ack_lat  = TO;
        ack_data = 32'h0000_1234;
        do_req(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
        wait_idle();

        // Reset in the middle of a fetch access
        ack_lat  = 0;
        do_req(1'b0, 1'b0, 4'h0, 32'h0000_0500, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", bus.mem_req, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_rvalid", {bus.ls_rvalid, bus.if_rvalid}, 0);
        sb.delete();
        gl_owner.delete();
        gl_cyc.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ack_lat      = 2;
        ack_data     = 32'h0000_ABCD;
        bus.if_addr  = 32'h0000_0600;
        bus.ls_addr  = 32'h0000_0700;
        bus.ls_we    = 1'b0;
        bus.ls_be    = 4'hF;
        bus.if_req   = 1'b1;
        bus.ls_req   = 1'b1;
        wait_grants(2);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        wait_idle();
        chk("post_rst_count", gl_owner.size(), 2);
        if (gl_owner.size() == 2) begin
            chk("post_rst_first", gl_owner[0], OWN_IF);
            chk("post_rst_second", gl_owner[1], OWN_LS);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one variable-latency memory port between instruction fetch (read-only) and the LSU (read/write with byte enables) in the multi-cycle core.
- Arbitrates with two-way round-robin and sequences each access through a fixed FSM.
- Returns read data or write completion to the granted requester.
- Includes a watchdog that terminates hung accesses with an error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYC, 255, maximum cycles in ACCESS before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle fetch response pulse.
- if_rdata  out  DATA_W  fetch read data.
- if_err  out  1  fetch response is a timeout error.
- ls_req  in  1  LSU request; held with payload until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_be  in  DATA_W/8  byte enables.
- ls_addr  in  ADDR_W  LSU address.
- ls_wdata  in  DATA_W  LSU write data.
- ls_gnt  out  1  LSU request accepted this cycle.
- ls_rvalid  out  1  one-cycle LSU response pulse (read data or write done).
- ls_rdata  out  DATA_W  LSU read data.
- ls_err  out  1  LSU response is a timeout error.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, last_owner = LS (so fetch wins the first tie).
  - Watchdog counter = 0.
  - All outputs = 0, including mem_req, mid-access. No response is ever issued for an aborted access.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is combinational. Only one req: grant it. Both req: grant the requester that is not last_owner.
  - Exactly one gnt is high in the grant cycle, never both.
  - On grant: latch owner, addr, we, be, wdata; set last_owner = owner; go to ACCESS next cycle.
  - Fetch grants latch we = 0 and be = all ones.
- ACCESS:
  - mem_req = 1 with the latched payload, held stable every cycle until exit.
  - Watchdog increments every cycle spent in ACCESS.
  - mem_ack = 1: capture mem_rdata, err = 0, go to RESP.
  - Otherwise, if TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1: rdata = 0, err = 1, go to RESP. mem_req drops on exit.
  - mem_ack in the same cycle as timeout: the ack wins and err = 0.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle, with the registered rdata/err.
  - For writes, rdata = mem_rdata captured (don't-care).
  - Watchdog clears; next state IDLE. No grants are issued in RESP.
- Idle values: non-owner rvalid/err = 0. rdata outputs hold their last value. mem_* payload outputs hold when mem_req = 0.
- Timing: grant at cycle t, mem_req from t+1, earliest ack at t+1, rvalid at t+2, next grant earliest at t+3.
- A req deasserted before gnt is simply not served; there is no requester-side abort after gnt.
- Watchdog width: $clog2(TIMEOUT_CYC+1), minimum 1 bit.

Decomposition:
- Shared package, used by the core top and the bench:
  - arb_state_e {IDLE, ACCESS, RESP}.
  - owner_e {OWN_IF, OWN_LS}.
  - Default widths.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: grant one-hot, owner.
- FSM, payload latch and watchdog stay in mem_arbiter.

Test Plan:
- Single fetch: if_req, addr 0x0000_0100; mem_ack 3 cycles after mem_req with rdata 0x0051_3093 -> if_gnt at t, mem_req t+1..t+3 with addr 0x100, we 0, be 0xF, if_rvalid at t+4 with data 0x0051_3093, if_err 0.
- Contention after reset: if_req and ls_req both held continuously, ack at 1 cycle -> grants alternate IF, LS, IF, LS, grants spaced 3 cycles apart, never both gnt high.
- LSU byte write: ls_we 1, be 0b0100, addr 0x2002, wdata 0xAABB_CCDD -> mem_we 1, mem_be 0b0100, payload stable while mem_req; ls_rvalid one pulse; if_rvalid stays 0.
- Timeout: TIMEOUT_CYC = 4, never ack -> mem_req high exactly 4 cycles, then ls_rvalid = 1, ls_err = 1, ls_rdata = 0; next request served normally.
- Ack on the timeout cycle: TIMEOUT_CYC = 4, ack on the 4th ACCESS cycle with 0x1234 -> rvalid with err 0, rdata 0x1234.
- Reset mid-access: assert rst_n = 0 during ACCESS -> mem_req drops without waiting for clk, no rvalid ever issued; after release, both req -> fetch granted first.
